// File: rtl/addsub_pipe_flags.sv
// addsub_pipe_flags: pipelined adder/subtractor with registered status flags.
// Each pipeline stage resolves one CHUNK-bit slice of the sum. The carry ripples
// from one stage register to the next instead of through one long chain. The
// operands travel down the pipe with the partial result (operand skew). The
// final stage registers z and the flags together.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand beat handshake (in_ready = !stall)
//   x, y, mode, cin       operands; mode 00 add, 01 sub, 10 add+cin, 11 sub-borrow
//   out_valid / out_ready result beat handshake
//   z                     result
//   sign, zero, carry,    per-result flags, registered with z
//   parity, overflow
//   ovf_sticky            set by any consumed result that has overflow=1
//   clr_sticky            synchronous clear of ovf_sticky (a set in the same cycle wins)
module addsub_pipe_flags #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [1:0]       mode,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             sign,
  output logic             zero,
  output logic             carry,
  output logic             parity,
  output logic             overflow,
  output logic             ovf_sticky,
  input  logic             clr_sticky
);

  localparam int unsigned NSTG = WIDTH / CHUNK;
  // Operands are needed only by stages 1..NSTG-1, so NSTG-1 operand registers suffice.
  localparam int unsigned NOPS = (NSTG > 1) ? NSTG - 1 : 1;

  typedef logic [WIDTH-1:0] word_t;

  // Stage registers
  word_t           x_q  [NOPS];
  word_t           yb_q [NOPS];
  word_t           z_q  [NSTG];
  logic [NSTG-1:0] c_q;
  logic [NSTG-1:0] vld_q;
  logic            sign_q, zero_q, parity_q, ovf_q, sticky_q;

  // Stage inputs (source) and stage results
  word_t           xs_a [NSTG];
  word_t           ys_a [NSTG];
  word_t           zi_a [NSTG];
  word_t           zo_a [NSTG];
  logic [NSTG-1:0] ci_a, co_a, vi_a;
  logic            stall;
  logic            c0;
  logic            sign_d, zero_d, parity_d, ovf_d, sticky_d;
  word_t           zf;

  // Adds chunk k of a and b with carry ci, and merges the chunk into zin.
  function automatic logic [WIDTH:0] chunk_add(input word_t a, input word_t b,
                                               input word_t zin, input logic ci,
                                               input int unsigned k);
    logic [CHUNK:0] s;
    word_t          zo;
    s  = {1'b0, a[k*CHUNK +: CHUNK]} + {1'b0, b[k*CHUNK +: CHUNK]} + {{CHUNK{1'b0}}, ci};
    zo = zin;
    zo[k*CHUNK +: CHUNK] = s[CHUNK-1:0];
    return {s[CHUNK], zo};
  endfunction

  always_comb begin
    stall = vld_q[NSTG-1] && !out_ready;
    ci_a  = '0;
    vi_a  = '0;
    co_a  = '0;

    case (mode)
      2'b00:   c0 = 1'b0;
      2'b01:   c0 = 1'b1;
      2'b10:   c0 = cin;
      default: c0 = ~cin;
    endcase

    xs_a[0]  = x;
    ys_a[0]  = mode[0] ? ~y : y;
    zi_a[0]  = '0;
    ci_a[0]  = c0;
    vi_a[0]  = in_valid;
    for (int unsigned k = 1; k < NSTG; k++) begin
      xs_a[k] = x_q[k-1];
      ys_a[k] = yb_q[k-1];
      zi_a[k] = z_q[k-1];
      ci_a[k] = c_q[k-1];
      vi_a[k] = vld_q[k-1];
    end

    for (int unsigned k = 0; k < NSTG; k++) begin
      {co_a[k], zo_a[k]} = chunk_add(xs_a[k], ys_a[k], zi_a[k], ci_a[k], k);
    end

    zf       = zo_a[NSTG-1];
    sign_d   = zf[WIDTH-1];
    zero_d   = ~|zf;
    parity_d = ~^zf;
    ovf_d    = (xs_a[NSTG-1][WIDTH-1] == ys_a[NSTG-1][WIDTH-1]) &&
               (zf[WIDTH-1] != xs_a[NSTG-1][WIDTH-1]);

    sticky_d = sticky_q;
    if (clr_sticky) sticky_d = 1'b0;
    if (vld_q[NSTG-1] && out_ready && ovf_q) sticky_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q    <= '0;
      c_q      <= '0;
      sign_q   <= 1'b0;
      zero_q   <= 1'b0;
      parity_q <= 1'b0;
      ovf_q    <= 1'b0;
      sticky_q <= 1'b0;
      for (int unsigned k = 0; k < NOPS; k++) begin
        x_q[k]  <= '0;
        yb_q[k] <= '0;
      end
      for (int unsigned k = 0; k < NSTG; k++) begin
        z_q[k] <= '0;
      end
    end else begin
      if (!stall) begin
        vld_q <= vi_a;
        // Data registers load only with a valid beat, so results hold through bubbles.
        for (int unsigned k = 0; k < NSTG; k++) begin
          if (vi_a[k]) begin
            z_q[k] <= zo_a[k];
            c_q[k] <= co_a[k];
          end
        end
        for (int unsigned k = 0; k + 1 < NSTG; k++) begin
          if (vi_a[k]) begin
            x_q[k]  <= xs_a[k];
            yb_q[k] <= ys_a[k];
          end
        end
        if (vi_a[NSTG-1]) begin
          sign_q   <= sign_d;
          zero_q   <= zero_d;
          parity_q <= parity_d;
          ovf_q    <= ovf_d;
        end
      end
      sticky_q <= sticky_d;
    end
  end

  assign in_ready   = !stall;
  assign out_valid  = vld_q[NSTG-1];
  assign z          = z_q[NSTG-1];
  assign carry      = c_q[NSTG-1];
  assign sign       = sign_q;
  assign zero       = zero_q;
  assign parity     = parity_q;
  assign overflow   = ovf_q;
  assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_addsub_pipe_flags.sv
module tb_addsub_pipe_flags;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, out_ready, cin, clr_sticky;
  logic [1:0]  mode;
  logic [15:0] x, y;
  logic        in_ready, out_valid, sign, zero, carry, parity, overflow, ovf_sticky;
  logic [15:0] z;
  logic [4:0]  flg;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign flg = {sign, zero, carry, parity, overflow};

  addsub_pipe_flags #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .mode(mode), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready), .z(z),
    .sign(sign), .zero(zero), .carry(carry), .parity(parity), .overflow(overflow),
    .ovf_sticky(ovf_sticky), .clr_sticky(clr_sticky)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("%s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: {sign, zero, carry, parity, overflow, z}
  function automatic logic [20:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic [1:0] m, input logic c);
    logic [15:0] bb;
    logic        c1;
    logic [16:0] s;
    logic        ov;
    bb = m[0] ? ~b : b;
    case (m)
      2'd0:    c1 = 1'b0;
      2'd1:    c1 = 1'b1;
      2'd2:    c1 = c;
      default: c1 = ~c;
    endcase
    s  = {1'b0, a} + {1'b0, bb} + {16'b0, c1};
    ov = (a[15] == bb[15]) && (s[15] != a[15]);
    return {s[15], ~|s[15:0], s[16], ~^s[15:0], ov, s[15:0]};
  endfunction

  // One isolated beat: checks acceptance, latency, result and flags; the
  // result is consumed on the final tick with clr_sticky = clr.
  task automatic single(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] m, input logic c, input logic [15:0] ez,
                        input logic [4:0] ef, input logic clr);
    int n;
    x = a; y = b; mode = m; cin = c; in_valid = 1'b1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    x = 16'hDEAD; y = 16'hBEEF; mode = ~m; cin = ~c;
    n = 0;
    while (!out_valid && n < 8) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd3);
    chk({tag, "_z"}, 32'(z), 32'(ez));
    chk({tag, "_flags"}, 32'(flg), 32'(ef));
    clr_sticky = clr;
    tick();
    clr_sticky = 1'b0;
  endtask

  logic [15:0] bx [6];
  logic [15:0] by [6];
  logic [1:0]  bm [6];
  logic        bc [6];
  logic [20:0] e;

  initial begin
    int sent, recv, stall_left, stray;
    logic seen_first;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_sticky = 1'b0;
    x = '0; y = '0; mode = '0; cin = 1'b0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_z", 32'(z), 32'd0);
    chk("rst_flags", 32'(flg), 32'd0);
    chk("rst_sticky", 32'(ovf_sticky), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // flags order: sign zero carry parity overflow
    single("add_ovf", 16'h8FFF, 16'h8000, 2'b00, 1'b0, 16'h0FFF, 5'b00111, 1'b0);
    chk("sticky_set", 32'(ovf_sticky), 32'd1);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    chk("sticky_clr", 32'(ovf_sticky), 32'd0);

    single("add_wrap", 16'hFFFE, 16'h0002, 2'b00, 1'b0, 16'h0000, 5'b01110, 1'b0);
    single("addc",     16'h0AAA, 16'h5555, 2'b10, 1'b1, 16'h6000, 5'b00010, 1'b0);
    single("sub_neg",  16'h0003, 16'h0005, 2'b01, 1'b0, 16'hFFFE, 5'b10000, 1'b0);
    chk("sticky_stays_clear", 32'(ovf_sticky), 32'd0);
    single("sub_ovf",  16'h8000, 16'h0001, 2'b01, 1'b0, 16'h7FFF, 5'b00101, 1'b1);
    chk("sticky_set_wins", 32'(ovf_sticky), 32'd1);
    single("subb_b1",  16'h0010, 16'h0001, 2'b11, 1'b1, 16'h000E, 5'b00100, 1'b0);
    single("subb_b0",  16'h0005, 16'h0005, 2'b11, 1'b0, 16'h0000, 5'b01110, 1'b0);

    // Back-to-back beats with a 3-cycle stall when the first result appears
    bx = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0F0F, 16'h8000, 16'hAAAA};
    by = '{16'h4321, 16'h0001, 16'h0001, 16'hF0F1, 16'h8000, 16'h5555};
    bm = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd3, 2'd1};
    bc = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    sent = 0; recv = 0; stall_left = 0; seen_first = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (out_valid && !seen_first) begin
        seen_first = 1'b1;
        stall_left = 3;
      end
      out_ready = (stall_left == 0);
      in_valid  = (sent < 6);
      if (sent < 6) begin
        x = bx[sent]; y = by[sent]; mode = bm[sent]; cin = bc[sent];
      end
      #1;
      if (stall_left > 0) begin
        chk("bp_stall_valid", 32'(out_valid), 32'd1);
        chk("bp_in_ready_stall", 32'(in_ready), 32'd0);
      end else begin
        chk("bp_in_ready", 32'(in_ready), 32'd1);
      end
      if (out_valid && out_ready) begin
        if (recv < 6) begin
          e = model(bx[recv], by[recv], bm[recv], bc[recv]);
          chk("bp_z", 32'(z), 32'(e[15:0]));
          chk("bp_flags", 32'(flg), 32'(e[20:16]));
        end
        recv++;
      end
      if (in_valid && in_ready) sent++;
      if (stall_left > 0) stall_left--;
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_sent", 32'(sent), 32'd6);
    chk("bp_recv", 32'(recv), 32'd6);
    chk("bp_seen_stall", 32'(seen_first), 32'd1);

    // Reset with three beats in flight
    for (int i = 0; i < 3; i++) begin
      x = 16'h0100 + 16'(i); y = 16'h0001; mode = 2'b00; cin = 1'b0; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_z", 32'(z), 32'd0);
    chk("mid_rst_flags", 32'(flg), 32'd0);
    chk("mid_rst_sticky", 32'(ovf_sticky), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) stray++;
    end
    chk("rst_no_stale", 32'(stray), 32'd0);
    single("post_rst", 16'h0001, 16'h0001, 2'b00, 1'b0, 16'h0002, 5'b00000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/addsub_pipe_flags.md
# addsub_pipe_flags

Parametrised, pipelined adder/subtractor with registered status flags. It is the next generation of the team's 16-bit flag-generating adder. Width and carry-chunk size are parameters. One chunk is resolved per pipeline stage, so carry ripples across registers rather than through one long combinational chain. Four arithmetic modes are supported, plus a valid/ready handshake with backpressure and a sticky overflow flag. It sits in the datapath between the operand register file and the result write-back.

## Interface

- WIDTH, 16: operand/result width; must be a multiple of CHUNK, ≥ CHUNK.
- CHUNK, 4: bits resolved per pipeline stage; NSTG = WIDTH/CHUNK stages.
- clk  in  1  rising-edge clock, single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  pipeline can accept a beat this cycle.
- x  in  WIDTH  operand A.
- y  in  WIDTH  operand B.
- mode  in  2  00 add; 01 sub; 10 add with cin; 11 sub with borrow-in.
- cin  in  1  carry-in, used only in modes 10/11.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts result.
- z  out  WIDTH  result.
- sign, zero, carry, parity, overflow  out  1 each  per-result flags.
- ovf_sticky  out  1  set by any accepted result with overflow=1.
- clr_sticky  in  1  synchronous clear of ovf_sticky.

## Operation

- Effective operand: yb = y for modes 00/10, ~y for 01/11.
- Carry-in c0: mode 00 → 0; 01 → 1; 10 → cin; 11 → ~cin (cin=1 means borrow-in).
- Result: {carry, z} = x + yb + c0, all WIDTH+1 bits exact, no saturation.
- Stage k (0..NSTG-1) adds chunk k of x and yb with the carry registered from stage k-1. Unresolved upper operand chunks and resolved lower result chunks travel alongside the carry (operand skew).
- The final stage computes the flags combinationally from the complete z and registers them with z:
  - sign = z[WIDTH-1].
  - zero = ~|z.
  - parity = ~^z (1 = even number of ones).
  - carry = raw carry-out. For subtract this is the ARM convention: 1 = no borrow.
  - overflow = (x[MSB] == yb[MSB]) && (z[MSB] != x[MSB]).
- Handshake:
  - stall = out_valid && !out_ready.
  - in_ready = !stall.
  - When stall is asserted, every stage register, including the valid bits, holds.
  - A beat is accepted when in_valid && in_ready. A result is consumed when out_valid && out_ready.
  - Beats never drop, duplicate or reorder.
- Sticky flag:
  - ovf_sticky sets on a consumed result with overflow=1.
  - clr_sticky clears it.
  - If set and clear occur in the same cycle, set wins.

## Timing

- Latency NSTG cycles from beat acceptance to out_valid when there is no stall (4 for defaults).
- Throughput is one beat per cycle at out_ready=1.
- z, flags and out_valid are all registered outputs, with no combinational input-to-output path except in_ready ← out_ready.
- Reset (asynchronous, any time including mid-pipeline):
  - All stage valids clear, so in-flight beats are discarded.
  - out_valid=0, z=0, sign=0, zero=0, carry=0, parity=0, overflow=0, ovf_sticky=0.
  - in_ready=1 during and after reset.
- Data and flags are only meaningful while out_valid=1. When no beat is present they hold their last value; they do not zero.
- Simultaneous consume and accept while the pipe is full is legal and sustains full rate.
- x, y, mode and cin are sampled only on acceptance. Changing them while in_valid=0 or in_ready=0 has no effect.

## Test plan

- Mode 00, x=0x8FFF, y=0x8000 → after 4 cycles z=0x0FFF, carry=1, overflow=1, sign=0, zero=0, parity=1, ovf_sticky=1 the cycle after consumption.
- Mode 00, x=0xFFFE, y=0x0002 → z=0x0000, carry=1, zero=1, overflow=0, parity=1; then mode 10, x=0x0AAA, y=0x5555, cin=1 → z=0x6000, carry=0, parity=1.
- Mode 01, x=0x0003, y=0x0005 → z=0xFFFE, carry=0, sign=1, overflow=0, parity=0; mode 01, x=0x8000, y=0x0001 → z=0x7FFF, overflow=1, carry=1.
- Six back-to-back beats with out_ready held low for 3 cycles once the first result appears:
  - in_ready drops in the same cycle as the stall.
  - All six results emerge in order with correct flags, none lost or duplicated.
- Assert clr_sticky alone → ovf_sticky=0 next cycle. Assert clr_sticky in the same cycle as an overflowing result is consumed → ovf_sticky stays 1.
- Pulse rst_n low while 3 beats are in flight:
  - out_valid=0 and all flags 0 immediately.
  - No stale beat emerges after release.
  - A new beat 0x0001+0x0001 returns z=0x0002 four cycles after acceptance.
